// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared types, size-mask constants and width helpers for the LSU.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_DONE  = 3'd5
    } lsu_state_e;

    typedef enum logic [1:0] {
        FC_NONE         = 2'd0,
        FC_MISALIGNED   = 2'd1,
        FC_BUS_ERR      = 2'd2,
        FC_ILLEGAL_SIZE = 2'd3
    } fault_cause_e;

    localparam logic [7:0] SIZE_BYTE  = 8'h01;
    localparam logic [7:0] SIZE_HALF  = 8'h03;
    localparam logic [7:0] SIZE_WORD  = 8'h0F;
    localparam logic [7:0] SIZE_DWORD = 8'hFF;

    function automatic int lsu_nb(input int xlen);
        return xlen / 8;
    endfunction

    function automatic int lsu_offw(input int xlen);
        return $clog2(xlen / 8);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_if.sv
// ============================================================================
// Module   : lsu_if
// Purpose  : Decode-side request, data-bus and writeback signals of the LSU.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface lsu_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    localparam int NB = XLEN / 8;

    logic            i_valid;
    logic            o_ready;
    logic            i_mem_read;
    logic            i_mem_write;
    logic [NB-1:0]   i_d_size;
    logic            i_d_unsigned;
    logic [XLEN-1:0] i_addr;
    logic [XLEN-1:0] i_wdata;
    logic [RD_W-1:0] i_rd;

    logic            o_req;
    logic            o_we;
    logic [XLEN-1:0] o_addr;
    logic [NB-1:0]   o_be;
    logic [XLEN-1:0] o_wdata;
    logic            i_gnt;
    logic            i_rvalid;
    logic [XLEN-1:0] i_rdata;
    logic            i_err;

    logic            o_done;
    logic            o_wb_valid;
    logic [RD_W-1:0] o_wb_rd;
    logic [XLEN-1:0] o_wb_data;
    logic            o_fault;
    logic [1:0]      o_fault_cause;

    modport slave (
        input  i_valid, i_mem_read, i_mem_write, i_d_size, i_d_unsigned,
        input  i_addr, i_wdata, i_rd, i_gnt, i_rvalid, i_rdata, i_err,
        output o_ready, o_req, o_we, o_addr, o_be, o_wdata,
        output o_done, o_wb_valid, o_wb_rd, o_wb_data, o_fault, o_fault_cause
    );

    modport master (
        output i_valid, i_mem_read, i_mem_write, i_d_size, i_d_unsigned,
        output i_addr, i_wdata, i_rd, i_gnt, i_rvalid, i_rdata, i_err,
        input  o_ready, o_req, o_we, o_addr, o_be, o_wdata,
        input  o_done, o_wb_valid, o_wb_rd, o_wb_data, o_fault, o_fault_cause
    );

endinterface

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module   : lsu_align
// Purpose  : Store lane shifting into two beats; load realignment and extension.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int NB   = lsu_nb(XLEN),
    localparam int OFFW = lsu_offw(XLEN)
) (
    input  wire logic [OFFW-1:0] i_st_off,
    input  wire logic [NB-1:0]   i_st_size,
    input  wire logic [XLEN-1:0] i_st_wdata,
    output logic      [NB-1:0]   o_be_lo,
    output logic      [NB-1:0]   o_be_hi,
    output logic      [XLEN-1:0] o_wd_lo,
    output logic      [XLEN-1:0] o_wd_hi,
    input  wire logic [OFFW-1:0] i_ld_off,
    input  wire logic [NB-1:0]   i_ld_size,
    input  wire logic            i_ld_unsigned,
    input  wire logic [XLEN-1:0] i_ld_lo,
    input  wire logic [XLEN-1:0] i_ld_hi,
    output logic      [XLEN-1:0] o_ld_data
);

    logic [2*NB-1:0]   w_mask2;
    logic [2*XLEN-1:0] w_data2;
    logic [XLEN-1:0]   w_ld_shift;
    logic              w_sign;

    always_comb begin
        w_mask2 = {{NB{1'b0}}, i_st_size} << i_st_off;
        w_data2 = {{XLEN{1'b0}}, i_st_wdata} << {i_st_off, 3'b000};
        o_be_lo = w_mask2[NB-1:0];
        o_be_hi = w_mask2[2*NB-1:NB];
        o_wd_lo = w_data2[XLEN-1:0];
        o_wd_hi = w_data2[2*XLEN-1:XLEN];
    end

    // The last selected lane in ascending order is the top byte, whose MSB is the sign.
    always_comb begin
        w_ld_shift = XLEN'({i_ld_hi, i_ld_lo} >> {i_ld_off, 3'b000});
        w_sign     = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (i_ld_size[b]) begin
                w_sign = w_ld_shift[8*b+7];
            end
        end
        w_sign = w_sign & ~i_ld_unsigned;
        for (int b = 0; b < NB; b++) begin
            o_ld_data[8*b +: 8] = i_ld_size[b] ? w_ld_shift[8*b +: 8] : {8{w_sign}};
        end
    end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// Module   : lsu_ctrl
// Purpose  : Single-outstanding load/store sequencer with misaligned splitting.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int SPLIT_MISALIGNED = 1,
    parameter int RD_W             = 5
) (
    input  wire logic i_clk,
    input  wire logic i_rst_n,
    lsu_if.slave      bus
);

    localparam int NB   = lsu_nb(XLEN);
    localparam int OFFW = lsu_offw(XLEN);

    lsu_state_e      state_q, state_d;
    logic            ready_q, ready_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [NB-1:0]   be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [NB-1:0]   be_hi_q, be_hi_d;
    logic [XLEN-1:0] wd_hi_q, wd_hi_d;
    logic            split_q, split_d;
    logic            load_q, load_d;
    logic [OFFW-1:0] off_q, off_d;
    logic [NB-1:0]   size_q, size_d;
    logic            uns_q, uns_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            done_q, done_d;
    logic            wb_valid_q, wb_valid_d;
    logic [RD_W-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            fault_q, fault_d;
    fault_cause_e    cause_q, cause_d;

    logic [OFFW-1:0] w_off;
    logic [XLEN-1:0] w_base;
    logic [NB-1:0]   w_be_lo, w_be_hi;
    logic [XLEN-1:0] w_wd_lo, w_wd_hi;
    logic [XLEN-1:0] w_ld_lo, w_ld_hi, w_ld_data;
    logic            w_accept;
    logic            w_fin;
    fault_cause_e    w_fin_cause;

    assign w_off    = bus.i_addr[OFFW-1:0];
    assign w_base   = {bus.i_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign w_accept = bus.i_valid & (bus.i_mem_read | bus.i_mem_write);
    // In WAIT0 the live beat is the low half; in WAIT1 it is the high half.
    assign w_ld_lo  = (state_q == ST_WAIT1) ? lo_q : bus.i_rdata;
    assign w_ld_hi  = (state_q == ST_WAIT1) ? bus.i_rdata : '0;

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_st_off      (w_off),
        .i_st_size     (bus.i_d_size),
        .i_st_wdata    (bus.i_wdata),
        .o_be_lo       (w_be_lo),
        .o_be_hi       (w_be_hi),
        .o_wd_lo       (w_wd_lo),
        .o_wd_hi       (w_wd_hi),
        .i_ld_off      (off_q),
        .i_ld_size     (size_q),
        .i_ld_unsigned (uns_q),
        .i_ld_lo       (w_ld_lo),
        .i_ld_hi       (w_ld_hi),
        .o_ld_data     (w_ld_data)
    );

    always_comb begin
        state_d    = state_q;    ready_d   = ready_q;   req_d     = req_q;
        we_d       = we_q;       addr_d    = addr_q;    be_d      = be_q;
        wdata_d    = wdata_q;    be_hi_d   = be_hi_q;   wd_hi_d   = wd_hi_q;
        split_d    = split_q;    load_d    = load_q;    off_d     = off_q;
        size_d     = size_q;     uns_d     = uns_q;     lo_d      = lo_q;
        wb_rd_d    = wb_rd_q;    wb_data_d = wb_data_q; cause_d   = cause_q;
        done_d     = 1'b0;       wb_valid_d = 1'b0;     fault_d   = 1'b0;
        w_fin       = 1'b0;
        w_fin_cause = FC_NONE;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    ready_d = 1'b0;
                    load_d  = bus.i_mem_read;
                    off_d   = w_off;
                    size_d  = bus.i_d_size;
                    uns_d   = bus.i_d_unsigned;
                    wb_rd_d = bus.i_rd;
                    split_d = |w_be_hi;
                    be_hi_d = w_be_hi;
                    wd_hi_d = w_wd_hi;
                    if (bus.i_d_size == '0) begin
                        state_d     = ST_DONE;
                        w_fin       = 1'b1;
                        w_fin_cause = FC_ILLEGAL_SIZE;
                    end else if ((|w_be_hi) && (SPLIT_MISALIGNED == 0)) begin
                        state_d     = ST_DONE;
                        w_fin       = 1'b1;
                        w_fin_cause = FC_MISALIGNED;
                    end else begin
                        state_d = ST_REQ0;
                        req_d   = 1'b1;
                        we_d    = ~bus.i_mem_read;
                        addr_d  = w_base;
                        be_d    = w_be_lo;
                        wdata_d = w_wd_lo;
                    end
                end
            end
            ST_REQ0, ST_REQ1: begin
                if (bus.i_gnt) begin
                    req_d   = 1'b0;
                    state_d = (state_q == ST_REQ0) ? ST_WAIT0 : ST_WAIT1;
                end
            end
            ST_WAIT0: begin
                if (bus.i_rvalid) begin
                    lo_d = bus.i_rdata;
                    if (bus.i_err) begin
                        state_d     = ST_DONE;
                        w_fin       = 1'b1;
                        w_fin_cause = FC_BUS_ERR;
                    end else if (split_q) begin
                        state_d = ST_REQ1;
                        req_d   = 1'b1;
                        addr_d  = addr_q + XLEN'(NB);
                        be_d    = be_hi_q;
                        wdata_d = wd_hi_q;
                    end else begin
                        state_d = ST_DONE;
                        w_fin   = 1'b1;
                    end
                end
            end
            ST_WAIT1: begin
                if (bus.i_rvalid) begin
                    state_d     = ST_DONE;
                    w_fin       = 1'b1;
                    w_fin_cause = bus.i_err ? FC_BUS_ERR : FC_NONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                req_d   = 1'b0;
            end
        endcase

        if (w_fin) begin
            done_d     = 1'b1;
            fault_d    = (w_fin_cause != FC_NONE);
            cause_d    = w_fin_cause;
            wb_valid_d = load_q && (w_fin_cause == FC_NONE);
            wb_data_d  = wb_valid_d ? w_ld_data : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;  ready_q <= 1'b1;   req_q <= 1'b0;   we_q <= 1'b0;
            addr_q  <= '0;       be_q    <= '0;     wdata_q <= '0;   be_hi_q <= '0;
            wd_hi_q <= '0;       split_q <= 1'b0;   load_q <= 1'b0;  off_q <= '0;
            size_q  <= '0;       uns_q   <= 1'b0;   lo_q <= '0;      done_q <= 1'b0;
            wb_valid_q <= 1'b0;  wb_rd_q <= '0;     wb_data_q <= '0; fault_q <= 1'b0;
            cause_q <= FC_NONE;
        end else begin
            state_q <= state_d;  ready_q <= ready_d; req_q <= req_d;  we_q <= we_d;
            addr_q  <= addr_d;   be_q    <= be_d;    wdata_q <= wdata_d; be_hi_q <= be_hi_d;
            wd_hi_q <= wd_hi_d;  split_q <= split_d; load_q <= load_d; off_q <= off_d;
            size_q  <= size_d;   uns_q   <= uns_d;   lo_q <= lo_d;     done_q <= done_d;
            wb_valid_q <= wb_valid_d; wb_rd_q <= wb_rd_d; wb_data_q <= wb_data_d;
            fault_q <= fault_d;  cause_q <= cause_d;
        end
    end

    assign bus.o_ready       = ready_q;
    assign bus.o_req         = req_q;
    assign bus.o_we          = we_q;
    assign bus.o_addr        = addr_q;
    assign bus.o_be          = be_q;
    assign bus.o_wdata       = wdata_q;
    assign bus.o_done        = done_q;
    assign bus.o_wb_valid    = wb_valid_q;
    assign bus.o_wb_rd       = wb_rd_q;
    assign bus.o_wb_data     = wb_data_q;
    assign bus.o_fault       = fault_q;
    assign bus.o_fault_cause = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// Module   : tb_lsu_ctrl
// Purpose  : Directed checks of lsu_ctrl at XLEN=32 (split on/off) and XLEN=64.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          sel;
    logic        valid, rd, wr, uns, gnt, rvalid, err;
    logic [7:0]  size;
    logic [63:0] addr, wdata, rdata;
    logic [4:0]  rdi;

    lsu_if #(.XLEN(32), .RD_W(5)) if_a ();
    lsu_if #(.XLEN(32), .RD_W(5)) if_b ();
    lsu_if #(.XLEN(64), .RD_W(5)) if_c ();

    assign if_a.i_valid = valid && (sel == 0);   assign if_b.i_valid = valid && (sel == 1);
    assign if_a.i_mem_read = rd;                 assign if_b.i_mem_read = rd;
    assign if_a.i_mem_write = wr;                assign if_b.i_mem_write = wr;
    assign if_a.i_d_size = size[3:0];            assign if_b.i_d_size = size[3:0];
    assign if_a.i_d_unsigned = uns;              assign if_b.i_d_unsigned = uns;
    assign if_a.i_addr = addr[31:0];             assign if_b.i_addr = addr[31:0];
    assign if_a.i_wdata = wdata[31:0];           assign if_b.i_wdata = wdata[31:0];
    assign if_a.i_rd = rdi;                      assign if_b.i_rd = rdi;
    assign if_a.i_gnt = gnt;                     assign if_b.i_gnt = gnt;
    assign if_a.i_rvalid = rvalid;               assign if_b.i_rvalid = rvalid;
    assign if_a.i_rdata = rdata[31:0];           assign if_b.i_rdata = rdata[31:0];
    assign if_a.i_err = err;                     assign if_b.i_err = err;

    assign if_c.i_valid = valid && (sel == 2);
    assign if_c.i_mem_read = rd;
    assign if_c.i_mem_write = wr;
    assign if_c.i_d_size = size;
    assign if_c.i_d_unsigned = uns;
    assign if_c.i_addr = addr;
    assign if_c.i_wdata = wdata;
    assign if_c.i_rd = rdi;
    assign if_c.i_gnt = gnt;
    assign if_c.i_rvalid = rvalid;
    assign if_c.i_rdata = rdata;
    assign if_c.i_err = err;

    lsu_ctrl #(.XLEN(32), .SPLIT_MISALIGNED(1), .RD_W(5)) u_a (.i_clk(clk), .i_rst_n(rst_n), .bus(if_a.slave));
    lsu_ctrl #(.XLEN(32), .SPLIT_MISALIGNED(0), .RD_W(5)) u_b (.i_clk(clk), .i_rst_n(rst_n), .bus(if_b.slave));
    lsu_ctrl #(.XLEN(64), .SPLIT_MISALIGNED(1), .RD_W(5)) u_c (.i_clk(clk), .i_rst_n(rst_n), .bus(if_c.slave));

    logic        ob_ready, ob_req, ob_we, ob_done, ob_wbv, ob_fault;
    logic [63:0] ob_addr, ob_wd, ob_wbd;
    logic [7:0]  ob_be;
    logic [4:0]  ob_wbrd;
    logic [1:0]  ob_cause;

    always_comb begin
        ob_ready = if_c.o_ready; ob_req = if_c.o_req; ob_we = if_c.o_we; ob_addr = if_c.o_addr;
        ob_be = if_c.o_be; ob_wd = if_c.o_wdata; ob_done = if_c.o_done; ob_wbv = if_c.o_wb_valid;
        ob_wbrd = if_c.o_wb_rd; ob_wbd = if_c.o_wb_data; ob_fault = if_c.o_fault; ob_cause = if_c.o_fault_cause;
        if (sel == 0) begin
            ob_ready = if_a.o_ready; ob_req = if_a.o_req; ob_we = if_a.o_we; ob_addr = 64'(if_a.o_addr);
            ob_be = 8'(if_a.o_be); ob_wd = 64'(if_a.o_wdata); ob_done = if_a.o_done; ob_wbv = if_a.o_wb_valid;
            ob_wbrd = if_a.o_wb_rd; ob_wbd = 64'(if_a.o_wb_data); ob_fault = if_a.o_fault; ob_cause = if_a.o_fault_cause;
        end else if (sel == 1) begin
            ob_ready = if_b.o_ready; ob_req = if_b.o_req; ob_we = if_b.o_we; ob_addr = 64'(if_b.o_addr);
            ob_be = 8'(if_b.o_be); ob_wd = 64'(if_b.o_wdata); ob_done = if_b.o_done; ob_wbv = if_b.o_wb_valid;
            ob_wbrd = if_b.o_wb_rd; ob_wbd = 64'(if_b.o_wb_data); ob_fault = if_b.o_fault; ob_cause = if_b.o_fault_cause;
        end
    end

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc, nb, hold0;
    logic        stable;
    logic [63:0] b_addr [2];
    logic [63:0] b_wd   [2];
    logic [7:0]  b_be   [2];
    logic        b_we   [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one request, plays the bus (gnt after gdly extra cycles, rvalid next cycle),
    // records each beat and returns when o_done is seen (cyc = -1 on timeout).
    task automatic run_txn(input int s, input logic r, input logic w, input logic u,
                           input logic [7:0] sz, input logic [63:0] a, input logic [63:0] wd,
                           input int gdly, input logic [63:0] lo, input logic [63:0] hi,
                           input int errb);
        int reqc;
        logic pend;
        @(posedge clk); #1;
        sel = s; rd = r; wr = w; uns = u; size = sz; addr = a; wdata = wd; valid = 1'b1;
        gnt = 0; rvalid = 0; err = 0;
        cyc = -1; nb = 0; hold0 = 0; stable = 1'b1; reqc = 0; pend = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            valid = 1'b0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
            if (ob_done) begin
                cyc = c;
                break;
            end
            if (pend) begin
                rvalid = 1'b1;
                rdata  = (nb == 1) ? lo : hi;
                err    = (errb == nb);
                pend   = 1'b0;
            end else if (ob_req && nb < 2) begin
                if (reqc == 0) begin
                    b_addr[nb] = ob_addr; b_be[nb] = ob_be; b_wd[nb] = ob_wd; b_we[nb] = ob_we;
                end else if (ob_addr !== b_addr[nb] || ob_be !== b_be[nb] || ob_wd !== b_wd[nb]) begin
                    stable = 1'b0;
                end
                reqc++;
                if (reqc > gdly) begin
                    gnt = 1'b1;
                    if (nb == 0) hold0 = reqc;
                    nb++;
                    reqc = 0;
                    pend = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 0; sel = 0; valid = 0; rd = 0; wr = 0; uns = 0; gnt = 0; rvalid = 0; err = 0;
        size = 0; addr = 0; wdata = 0; rdata = 0; rdi = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ob_ready, 1); chk("rst_req", ob_req, 0); chk("rst_done", ob_done, 0);
        chk("rst_addr", ob_addr, 0); chk("rst_cause", ob_cause, 0); chk("rst_wbd", ob_wbd, 0);
        rst_n = 1;

        // Aligned LW
        rdi = 5'd5;
        run_txn(0, 1, 0, 0, SIZE_WORD, 64'h100, 0, 0, 64'hDEADBEEF, 0, 0);
        chk("lw_cyc", cyc, 3); chk("lw_nb", nb, 1); chk("lw_addr", b_addr[0], 64'h100);
        chk("lw_be", b_be[0], 8'hF); chk("lw_we", b_we[0], 0); chk("lw_wbv", ob_wbv, 1);
        chk("lw_wbd", ob_wbd, 64'hDEADBEEF); chk("lw_wbrd", ob_wbrd, 5); chk("lw_fault", ob_fault, 0);
        @(posedge clk); #1;
        chk("lw_done_pulse", ob_done, 0); chk("lw_ready_back", ob_ready, 1);

        // LB signed/unsigned at lane 3; the second also sets write to test read priority
        run_txn(0, 1, 0, 0, SIZE_BYTE, 64'h103, 0, 0, 64'h80000000, 0, 0);
        chk("lb_be", b_be[0], 8'h8); chk("lb_s_wbd", ob_wbd, 64'hFFFFFF80);
        run_txn(0, 1, 1, 1, SIZE_BYTE, 64'h103, 0, 0, 64'h80000000, 0, 0);
        chk("lbu_we", b_we[0], 0); chk("lbu_wbv", ob_wbv, 1); chk("lbu_wbd", ob_wbd, 64'h80);

        // Split SW
        run_txn(0, 0, 1, 0, SIZE_WORD, 64'h102, 64'h11223344, 0, 0, 0, 0);
        chk("sw_cyc", cyc, 5); chk("sw_nb", nb, 2);
        chk("sw_a0", b_addr[0], 64'h100); chk("sw_be0", b_be[0], 8'hC); chk("sw_wd0", b_wd[0], 64'h33440000);
        chk("sw_we0", b_we[0], 1);
        chk("sw_a1", b_addr[1], 64'h104); chk("sw_be1", b_be[1], 8'h3); chk("sw_wd1", b_wd[1], 64'h1122);
        chk("sw_wbv", ob_wbv, 0); chk("sw_wbd", ob_wbd, 0); chk("sw_fault", ob_fault, 0);

        // Misaligned LH with splitting disabled
        run_txn(1, 1, 0, 0, SIZE_HALF, 64'h103, 0, 0, 0, 0, 0);
        chk("mis_cyc", cyc, 1); chk("mis_nb", nb, 0); chk("mis_fault", ob_fault, 1);
        chk("mis_cause", ob_cause, FC_MISALIGNED); chk("mis_wbv", ob_wbv, 0);

        // LW with delayed grant and bus error
        run_txn(0, 1, 0, 0, SIZE_WORD, 64'h200, 0, 4, 64'h12345678, 0, 1);
        chk("err_hold", hold0, 5); chk("err_stable", stable, 1); chk("err_addr", b_addr[0], 64'h200);
        chk("err_cyc", cyc, 7); chk("err_fault", ob_fault, 1); chk("err_cause", ob_cause, FC_BUS_ERR);
        chk("err_wbv", ob_wbv, 0); chk("err_wbd", ob_wbd, 0);

        // Zero size mask
        run_txn(0, 1, 0, 0, 8'h00, 64'h100, 0, 0, 0, 0, 0);
        chk("ill_cyc", cyc, 1); chk("ill_nb", nb, 0); chk("ill_cause", ob_cause, FC_ILLEGAL_SIZE);

        // Split loads, including sign extension across beats and address wrap
        run_txn(0, 1, 0, 0, SIZE_WORD, 64'h101, 0, 0, 64'hAABBCCDD, 64'h11223344, 0);
        chk("slw_cyc", cyc, 5); chk("slw_be0", b_be[0], 8'hE); chk("slw_be1", b_be[1], 8'h1);
        chk("slw_wbd", ob_wbd, 64'h44AABBCC);
        run_txn(0, 1, 0, 0, SIZE_HALF, 64'h103, 0, 0, 64'hFF000000, 64'h000000F1, 0);
        chk("slh_wbd", ob_wbd, 64'hFFFFF1FF);
        run_txn(0, 1, 0, 0, SIZE_WORD, 64'hFFFFFFFE, 0, 0, 64'h56780000, 64'h00001234, 0);
        chk("wrap_a1", b_addr[1], 64'h0); chk("wrap_wbd", ob_wbd, 64'h12345678);

        // Bus error on the first beat of a split store: no second beat
        run_txn(0, 0, 1, 0, SIZE_WORD, 64'h102, 64'h11223344, 0, 0, 0, 1);
        chk("serr_nb", nb, 1); chk("serr_cause", ob_cause, FC_BUS_ERR);

        // Reset while a request is pending drops o_req at once
        @(posedge clk); #1;
        sel = 0; rd = 1; wr = 0; size = SIZE_WORD; addr = 64'h300; valid = 1;
        @(posedge clk); #1;
        valid = 0;
        chk("rq_req_before", ob_req, 1);
        #2 rst_n = 0;
        #1;
        chk("rq_req_rst", ob_req, 0); chk("rq_ready_rst", ob_ready, 1); chk("rq_addr_rst", ob_addr, 0);
        @(posedge clk); #1 rst_n = 1;

        // XLEN=64: reset in WAIT0 with a response on the bus
        @(posedge clk); #1;
        sel = 2; rd = 1; wr = 0; uns = 0; size = SIZE_WORD; addr = 64'h1006; valid = 1;
        @(posedge clk); #1;
        valid = 0;
        chk("x_req", ob_req, 1); chk("x_addr", ob_addr, 64'h1000); chk("x_be", ob_be, 8'hC0);
        gnt = 1;
        @(posedge clk); #1;
        gnt = 0;
        chk("x_wait_req", ob_req, 0);
        rvalid = 1; rdata = 64'hCAFEF00D_00000000;
        #2 rst_n = 0;
        #1;
        chk("x_rst_done", ob_done, 0); chk("x_rst_ready", ob_ready, 1);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        chk("x_post_done0", ob_done, 0);
        rvalid = 0;
        @(posedge clk); #1;
        chk("x_post_done1", ob_done, 0); chk("x_post_ready", ob_ready, 1);

        run_txn(2, 1, 0, 0, SIZE_DWORD, 64'h1000, 0, 0, 64'h0123456789ABCDEF, 0, 0);
        chk("ld_cyc", cyc, 3); chk("ld_addr", b_addr[0], 64'h1000); chk("ld_be", b_be[0], 8'hFF);
        chk("ld_wbd", ob_wbd, 64'h0123456789ABCDEF);
        run_txn(2, 1, 0, 0, SIZE_WORD, 64'h1004, 0, 0, 64'h80000000_00000000, 0, 0);
        chk("lw64_be", b_be[0], 8'hF0); chk("lw64_wbd", ob_wbd, 64'hFFFFFFFF80000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Parametrised load/store sequencer between the decode stage and the data-memory bus. Consumes the decoder's per-instruction memory controls (read/write, byte-mask size, unsigned) plus address and store data. Drives a single-outstanding req/gnt/rvalid bus and returns aligned, sign/zero-extended load data for writeback. Generalises data width to XLEN and adds misaligned-access splitting into two bus beats, bus-error reporting and a busy handshake for pipeline stalls.

Parameters:
XLEN, 32, data/address width; 32 or 64; NB = XLEN/8 byte lanes.
SPLIT_MISALIGNED, 1, 1: split lane-crossing accesses into two beats; 0: fault them without a bus request.
RD_W, 5, destination register index width.

Ports:
i_clk  in  1  clock; all state on rising edge.
i_rst_n  in  1  asynchronous, active-low reset.
i_valid  in  1  request valid; accepted only when o_ready=1.
o_ready  out  1  high only in IDLE.
i_mem_read  in  1  load request.
i_mem_write  in  1  store request (i_mem_read has priority if both set).
i_d_size  in  NB  contiguous byte mask from bit 0 (0001, 0011, 1111, 8'hFF when XLEN=64).
i_d_unsigned  in  1  zero-extend load result.
i_addr  in  XLEN  byte address.
i_wdata  in  XLEN  store data, LSB-aligned.
i_rd  in  RD_W  load destination register.
o_req  out  1  bus request; held until i_gnt.
o_we  out  1  bus write.
o_addr  out  XLEN  NB-aligned bus address.
o_be  out  NB  byte enables.
o_wdata  out  XLEN  lane-shifted store data.
i_gnt  in  1  request accepted this cycle.
i_rvalid  in  1  beat response (read data or write ack); never in the cycle of i_gnt.
i_rdata  in  XLEN  read data.
i_err  in  1  bus error, qualified by i_rvalid.
o_done  out  1  one-cycle completion pulse.
o_wb_valid  out  1  o_done and load and no fault.
o_wb_rd  out  RD_W  latched i_rd.
o_wb_data  out  XLEN  extended load result.
o_fault  out  1  qualified by o_done.
o_fault_cause  out  2  NONE=0, MISALIGNED=1, BUS_ERR=2, ILLEGAL_SIZE=3.

Behaviour:
- Reset (async assert, sync release): state IDLE; o_ready=1; o_req, o_we, o_done, o_wb_valid, o_fault=0; o_addr, o_be, o_wdata, o_wb_data, o_wb_rd, o_fault_cause=0. Reset mid-transaction drops o_req immediately; any in-flight response is ignored after release.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- IDLE: accept on i_valid & (read|write). Latch all inputs. off = addr[log2(NB)-1:0]; mask2 = size << off (2*NB bits); wdata2 = wdata << 8*off (2*XLEN bits); be_lo/hi and wd_lo/hi = low/high halves; split = |be_hi.
- i_d_size == 0: -> DONE, fault ILLEGAL_SIZE, no bus request. split & !SPLIT_MISALIGNED: -> DONE, fault MISALIGNED, no bus request. Otherwise -> REQ0.
- REQ0: o_req=1, o_addr=aligned addr, o_be=be_lo, o_wdata=wd_lo; outputs stable until i_gnt; on i_gnt -> WAIT0.
- WAIT0: on i_rvalid: capture i_rdata as lo beat. If i_err -> DONE, BUS_ERR. Else split -> REQ1, else -> DONE.
- REQ1/WAIT1: same, aligned addr + NB (wraps modulo 2^XLEN), be_hi, wd_hi; capture hi beat; error -> BUS_ERR.
- DONE: o_done=1 for exactly one cycle; loads without fault: o_wb_valid=1, o_wb_data = ({hi,lo} >> 8*off) masked to size bytes, extended from top selected byte's MSB unless unsigned; stores: o_wb_data=0. -> IDLE; o_ready asserts the following cycle.
- Fault: o_wb_valid=0, o_wb_data=0. A BUS_ERR on the first beat of a split access issues no second beat (partial store possible, documented).
- Latency (i_gnt same cycle as o_req, i_rvalid next cycle): aligned access accept at cycle 0, o_done at cycle 3; split access o_done at cycle 5.
- i_valid while busy: ignored; upstream holds it until o_ready.

Decomposition:
- Package lsu_pkg: state enum, fault-cause enum, SIZE_BYTE/HALF/WORD/DWORD mask constants, NB/log2 helpers.
- Sub-module lsu_align (combinational): mask/data lane shift for stores and right-shift/mask/extend for loads; lsu_ctrl holds the FSM and registers.

Test Plan:
- XLEN=32, LW addr 0x100, rdata 0xDEADBEEF, immediate gnt -> o_addr 0x100, o_be 1111; o_done at cycle 3; o_wb_data 0xDEADBEEF.
- LB addr 0x103, rdata 0x80_00_00_00, signed then unsigned -> o_be 1000; o_wb_data 0xFFFFFF80 / 0x00000080.
- SW 0x11223344 to 0x102, SPLIT=1 -> beat0 addr 0x100, be 1100, wdata 0x33440000; beat1 addr 0x104, be 0011, wdata 0x00001122; o_done cycle 5.
- LH addr 0x103 with SPLIT=0 -> no o_req; o_done with fault MISALIGNED; o_wb_valid=0.
- LW with gnt delayed 4 cycles, then rvalid with i_err -> o_req/o_addr stable 5 cycles; fault BUS_ERR; o_wb_valid=0.
- XLEN=64 LW addr 0x1006, reset asserted in WAIT0 -> o_req low same cycle, no o_done; after release next LD 0x1000 completes normally.
